// File: rtl/xosera_pkg.sv
// rtl/xosera_pkg.sv - shared types and sizes for the copper memory arbiter
package xosera_pkg;

    localparam int COPMEM_AWIDTH = 10;

    typedef enum logic [2:0] {
        H_IDLE,
        H_RD_WAIT,
        H_RD_ADDR,
        H_RD_DATA,
        H_DONE
    } copmem_host_st_t;

endpackage

// File: rtl/copmem_arbiter.sv
// rtl/copmem_arbiter.sv - copper/host arbiter for the dual-half copper program memory
module copmem_arbiter
    import xosera_pkg::*;
#(
    parameter int AWIDTH        = COPMEM_AWIDTH,
    parameter int HOST_MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset_i,
    input  logic              cop_rd_req_i,
    input  logic [AWIDTH-1:0] cop_rd_addr_i,
    output logic              cop_rd_grant_o,
    output logic              cop_rd_valid_o,
    output logic [31:0]       cop_rd_data_o,
    input  logic              host_req_i,
    input  logic              host_wr_i,
    input  logic [AWIDTH:0]   host_addr_i,
    input  logic [15:0]       host_data_i,
    output logic              host_ack_o,
    output logic [15:0]       host_data_o,
    output logic [AWIDTH-1:0] mem_rd_addr_o,
    input  logic [15:0]       mem_rd_even_i,
    input  logic [15:0]       mem_rd_odd_i,
    output logic              mem_wr_even_o,
    output logic              mem_wr_odd_o,
    output logic [AWIDTH-1:0] mem_wr_addr_o,
    output logic [15:0]       mem_wr_data_o
);

    localparam int CW = (HOST_MAX_WAIT > 0) ? $clog2(HOST_MAX_WAIT + 1) : 1;
    localparam logic [CW-1:0] WAIT_MAX = CW'(HOST_MAX_WAIT);

    copmem_host_st_t   hst_q, hst_d;
    logic [CW-1:0]     wait_cnt_q, wait_cnt_d;
    logic [AWIDTH:0]   haddr_q, haddr_d;
    logic              host_ack_q, host_ack_d;
    logic [15:0]       host_data_q, host_data_d;
    logic [AWIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [1:0]        cop_vld_q, cop_vld_d;
    logic              wr_even_q, wr_even_d;
    logic              wr_odd_q, wr_odd_d;
    logic [AWIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [15:0]       wr_data_q, wr_data_d;

    logic              host_grant;
    logic              cop_grant;
    logic [15:0]       rd_half;

    always_comb begin
        host_grant = (hst_q == H_RD_WAIT) && (!cop_rd_req_i || (wait_cnt_q == WAIT_MAX));
        cop_grant  = cop_rd_req_i && !host_grant;
        rd_half    = haddr_q[0] ? mem_rd_odd_i : mem_rd_even_i;
    end

    always_comb begin
        hst_d       = hst_q;
        wait_cnt_d  = wait_cnt_q;
        haddr_d     = haddr_q;
        host_ack_d  = 1'b0;
        host_data_d = host_data_q;
        rd_addr_d   = rd_addr_q;
        wr_even_d   = 1'b0;
        wr_odd_d    = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        cop_vld_d   = {cop_vld_q[0], cop_grant};

        // read address only moves on a grant, otherwise the last one is held
        if (host_grant) begin
            rd_addr_d = haddr_q[AWIDTH:1];
        end else if (cop_grant) begin
            rd_addr_d = cop_rd_addr_i;
        end

        case (hst_q)
            H_IDLE: begin
                if (host_req_i) begin
                    if (host_wr_i) begin
                        wr_even_d  = ~host_addr_i[0];
                        wr_odd_d   = host_addr_i[0];
                        wr_addr_d  = host_addr_i[AWIDTH:1];
                        wr_data_d  = host_data_i;
                        host_ack_d = 1'b1;
                        hst_d      = H_DONE;
                    end else begin
                        haddr_d = host_addr_i;
                        hst_d   = H_RD_WAIT;
                    end
                end
            end
            H_RD_WAIT: begin
                if (host_grant) begin
                    wait_cnt_d = '0;
                    hst_d      = H_RD_ADDR;
                end else if (wait_cnt_q != WAIT_MAX) begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            H_RD_ADDR: begin
                host_ack_d = 1'b1;
                hst_d      = H_RD_DATA;
            end
            H_RD_DATA: begin
                host_data_d = rd_half;
                hst_d       = H_DONE;
            end
            H_DONE: begin
                if (!host_req_i) begin
                    hst_d = H_IDLE;
                end
            end
            default: hst_d = H_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            hst_q       <= H_IDLE;
            wait_cnt_q  <= '0;
            haddr_q     <= '0;
            host_ack_q  <= 1'b0;
            host_data_q <= '0;
            rd_addr_q   <= '0;
            cop_vld_q   <= '0;
            wr_even_q   <= 1'b0;
            wr_odd_q    <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            hst_q       <= hst_d;
            wait_cnt_q  <= wait_cnt_d;
            haddr_q     <= haddr_d;
            host_ack_q  <= host_ack_d;
            host_data_q <= host_data_d;
            rd_addr_q   <= rd_addr_d;
            cop_vld_q   <= cop_vld_d;
            wr_even_q   <= wr_even_d;
            wr_odd_q    <= wr_odd_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    // read data is shown live in the ack cycle and held in host_data_q afterwards
    assign host_data_o    = (hst_q == H_RD_DATA) ? rd_half : host_data_q;
    assign host_ack_o     = host_ack_q;
    assign cop_rd_grant_o = cop_grant;
    assign cop_rd_valid_o = cop_vld_q[1];
    assign cop_rd_data_o  = {mem_rd_even_i, mem_rd_odd_i};
    assign mem_rd_addr_o  = rd_addr_q;
    assign mem_wr_even_o  = wr_even_q;
    assign mem_wr_odd_o   = wr_odd_q;
    assign mem_wr_addr_o  = wr_addr_q;
    assign mem_wr_data_o  = wr_data_q;

endmodule
